// File: rtl/top_vector_gates.sv
// top_vector_gates
// Registered vector gate block. Each accepted a/b sample produces the
// bitwise OR, a single-bit "any bit set" flag and the inverted operands
// one cycle later. A saturating counter tracks how many accepted samples
// had at least one bit set. All outputs come straight from flops, so
// there is no combinational path from the inputs to the outputs.
module top_vector_gates #(
    parameter int W    = 3,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    output logic [W-1:0]      out_or_bitwise,
    output logic              out_or_logical,
    output logic [2*W-1:0]    out_not,
    output logic [CNTW-1:0]   nz_count
);

    // Combined OR of the operands, shared by the bitwise and logical results.
    logic [W-1:0] or_vec;
    logic         any_set;

    assign or_vec  = a | b;
    assign any_set = |or_vec;

    // Results load only on accepted samples and hold otherwise. The reset
    // value of out_not is all ones because it is the inverse of zero operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_or_bitwise <= '0;
            out_or_logical <= 1'b0;
            out_not        <= '1;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_or_bitwise <= or_vec;
                out_or_logical <= any_set;
                out_not        <= {~b, ~a};
            end
        end
    end

    // Count accepted non-zero samples, stopping at the all-ones value
    // so that the count never wraps back to a small number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_count <= '0;
        end else if (in_valid && any_set && (nz_count != {CNTW{1'b1}})) begin
            nz_count <= nz_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_top_vector_gates.sv
// tb_top_vector_gates
// Bench for top_vector_gates. Two instances share one stimulus stream:
// the default one (CNTW = 8) and a narrow-counter one (CNTW = 2) that
// exercises counter saturation quickly. A behavioural model derives the
// expected outputs arithmetically and a compare process checks both DUTs
// every cycle; directed literal checks pin the model on known vectors.
module tb_top_vector_gates;

    localparam int W = 3;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;

    logic           out_valid;
    logic [W-1:0]   out_or_bitwise;
    logic           out_or_logical;
    logic [2*W-1:0] out_not;
    logic [7:0]     nz_count;

    logic           out_valid_n;
    logic [W-1:0]   out_or_bitwise_n;
    logic           out_or_logical_n;
    logic [2*W-1:0] out_not_n;
    logic [1:0]     nz_count_n;

    int assert_count = 0;
    int fail_count   = 0;
    bit check_en     = 1'b0;

    // model state
    int m_valid;
    int m_or;
    int m_log;
    int m_not;
    int m_cnt8;
    int m_cnt2;

    top_vector_gates #(.W(W), .CNTW(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .out_or_bitwise (out_or_bitwise),
        .out_or_logical (out_or_logical),
        .out_not        (out_not),
        .nz_count       (nz_count)
    );

    top_vector_gates #(.W(W), .CNTW(2)) dut_narrow (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid_n),
        .out_or_bitwise (out_or_bitwise_n),
        .out_or_logical (out_or_logical_n),
        .out_not        (out_not_n),
        .nz_count       (nz_count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value, counting the check and reporting any difference.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one input vector (caller is at a falling edge) and wait until
    // the following falling edge, by which time its result is registered.
    task automatic applyStimulus(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
        @(negedge clk);
    endtask

    // Behavioural model: results follow arithmetic on the integer values
    // of the operands; inversion of a 2W-bit word is (2^(2W)-1) - value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0;
            m_or    = 0;
            m_log   = 0;
            m_not   = (1 << (2 * W)) - 1;
            m_cnt8  = 0;
            m_cnt2  = 0;
        end else begin
            m_valid = in_valid ? 1 : 0;
            if (in_valid) begin
                m_or  = int'(a | b);
                m_log = (int'(a) + int'(b) > 0) ? 1 : 0;
                m_not = ((1 << (2 * W)) - 1) - (int'(b) * (1 << W) + int'(a));
                if (m_log == 1) begin
                    m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
                    m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
                end
            end
        end
    end

    // Every falling edge, both DUTs must agree with the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("valid",     64'(out_valid),        64'(m_valid));
            checkOutput("or_bit",    64'(out_or_bitwise),   64'(m_or));
            checkOutput("or_log",    64'(out_or_logical),   64'(m_log));
            checkOutput("not",       64'(out_not),          64'(m_not));
            checkOutput("nz8",       64'(nz_count),         64'(m_cnt8));
            checkOutput("valid_n",   64'(out_valid_n),      64'(m_valid));
            checkOutput("or_bit_n",  64'(out_or_bitwise_n), 64'(m_or));
            checkOutput("or_log_n",  64'(out_or_logical_n), 64'(m_log));
            checkOutput("not_n",     64'(out_not_n),        64'(m_not));
            checkOutput("nz2",       64'(nz_count_n),       64'(m_cnt2));
        end
    end

    // Literal reset values on both instances.
    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"}, 64'(out_valid),      64'd0);
        checkOutput({tag, "_or"},    64'(out_or_bitwise), 64'd0);
        checkOutput({tag, "_log"},   64'(out_or_logical), 64'd0);
        checkOutput({tag, "_not"},   64'(out_not),        64'h3f);
        checkOutput({tag, "_nz8"},   64'(nz_count),       64'd0);
        checkOutput({tag, "_nz2"},   64'(nz_count_n),     64'd0);
    endtask

    // Pulse reset between clock edges and release it on a falling edge.
    task automatic pulseReset();
        #2 rst_n = 1'b0;
        #1 checkReset("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] r;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        // initial asynchronous reset before the first rising edge
        #2 rst_n = 1'b0;
        #1 checkReset("por");
        check_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed: 101 | 010
        applyStimulus(1'b1, 3'b101, 3'b010);
        checkOutput("d1_or",    64'(out_or_bitwise), 64'b111);
        checkOutput("d1_log",   64'(out_or_logical), 64'd1);
        checkOutput("d1_not",   64'(out_not),        64'b101010);
        checkOutput("d1_valid", 64'(out_valid),      64'd1);
        checkOutput("d1_nz",    64'(nz_count),       64'd1);

        // directed: all zero, counter unchanged
        applyStimulus(1'b1, 3'b000, 3'b000);
        checkOutput("d2_or",    64'(out_or_bitwise), 64'b000);
        checkOutput("d2_log",   64'(out_or_logical), 64'd0);
        checkOutput("d2_not",   64'(out_not),        64'b111111);
        checkOutput("d2_nz",    64'(nz_count),       64'd1);

        // directed: b only, then three idle cycles hold the result
        applyStimulus(1'b1, 3'b000, 3'b100);
        checkOutput("d3_or",    64'(out_or_bitwise), 64'b100);
        checkOutput("d3_log",   64'(out_or_logical), 64'd1);
        checkOutput("d3_not",   64'(out_not),        64'b011111);
        checkOutput("d3_nz",    64'(nz_count),       64'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'b111, 3'b011);
            checkOutput("hold_valid", 64'(out_valid),      64'd0);
            checkOutput("hold_or",    64'(out_or_bitwise), 64'b100);
            checkOutput("hold_log",   64'(out_or_logical), 64'd1);
            checkOutput("hold_not",   64'(out_not),        64'b011111);
        end

        // narrow counter: five non-zero samples saturate at 3
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 3'(i + 1), 3'b000);
            checkOutput("sat_nz2", 64'(nz_count_n), 64'((i + 1 > 3) ? 3 : i + 1));
        end

        // exhaustive sweep of {b,a}
        for (int i = 0; i < 64; i++) begin
            r = 6'(i);
            applyStimulus(1'b1, r[2:0], r[5:3]);
        end

        // random values with in_valid toggling
        for (int i = 0; i < 400; i++) begin
            r = 6'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), r[2:0], r[5:3]);
        end

        // mid-stream reset: the in-flight sample is discarded
        in_valid = 1'b1;
        a        = 3'b111;
        b        = 3'b111;
        pulseReset();
        applyStimulus(1'b1, 3'b001, 3'b000);
        checkOutput("post_valid", 64'(out_valid),      64'd1);
        checkOutput("post_or",    64'(out_or_bitwise), 64'b001);
        checkOutput("post_not",   64'(out_not),        64'b111110);
        checkOutput("post_nz",    64'(nz_count),       64'd1);
        applyStimulus(1'b0, 3'b000, 3'b000);
        checkOutput("post_idle",  64'(out_valid),      64'd0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/top_vector_gates.md
TOP_VECTOR_GATES -- requirements
Module: top_vector_gates

Interface
REQ-001 SHALL have parameter W, default 3, giving the width of each operand vector (W >= 1).
REQ-002 SHALL have parameter CNTW, default 8, giving the width of the non-zero sample counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  when high, a/b are sampled this cycle.
REQ-006 a  input  W  operand vector A.
REQ-007 b  input  W  operand vector B.
REQ-008 out_valid  output  1  high for one cycle after each accepted sample.
REQ-009 out_or_bitwise  output  W  registered a | b.
REQ-010 out_or_logical  output  1  registered (a != 0) || (b != 0).
REQ-011 out_not  output  2W  registered {~b, ~a}: ~b in the upper W bits, ~a in the lower W bits.
REQ-012 nz_count  output  CNTW  saturating count of accepted samples with out_or_logical = 1.

Function
REQ-013 On a rising clk edge with in_valid = 1, the block SHALL register out_or_bitwise = a | b, out_or_logical = |(a | b) and out_not = {~b, ~a}; latency is exactly 1 cycle.
REQ-014 out_valid SHALL be registered in_valid: high in the cycle after an accepted sample, low otherwise.
REQ-015 With in_valid = 0, out_or_bitwise, out_or_logical and out_not SHALL hold their last values.
REQ-016 Back-to-back in_valid = 1 SHALL be accepted every cycle, with no bubbles and no backpressure.
REQ-017 out_or_logical SHALL be a single bit: 1 if any bit of a or b is 1, else 0; it is never a bitwise vector.
REQ-018 out_not bit ordering SHALL be out_not[2W-1:W] = ~b and out_not[W-1:0] = ~a, with bit i of ~a equal to the inverse of a[i].
REQ-019 nz_count SHALL increment by 1 on each accepted sample with (a | b) != 0, and SHALL saturate at 2^CNTW-1 without wrapping.
REQ-020 No output SHALL ever be X or Z once reset has been applied; the outputs depend only on registered state.
REQ-021 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-022 While rst_n = 0, all outputs SHALL immediately, without waiting for clk, take these values:
- out_valid = 0, out_or_bitwise = 0, out_or_logical = 0, nz_count = 0.
- out_not = all ones, which equals {~0, ~0}.
REQ-023 A reset asserted mid-stream SHALL discard any in-flight sample; the first sample accepted after release SHALL produce out_valid one cycle later.
REQ-024 Reset release SHALL be synchronised by the integrator; the block SHALL accept in_valid on the first rising edge with rst_n = 1.

Verification
REQ-025 The bench SHALL cover these directed scenarios, with W = 3 unless stated:
- a=3'b101, b=3'b010, in_valid=1 -> next cycle: out_or_bitwise=3'b111, out_or_logical=1, out_not=6'b101010, out_valid=1, nz_count=1.
- a=3'b000, b=3'b000, in_valid=1 -> out_or_bitwise=3'b000, out_or_logical=0, out_not=6'b111111, nz_count unchanged.
- a=3'b000, b=3'b100 -> out_or_bitwise=3'b100, out_or_logical=1, out_not=6'b011111; then in_valid=0 for 3 cycles -> outputs hold and out_valid=0.
- Exhaustive sweep of all 64 {b,a} values, then 400 random values with in_valid toggling -> each output matches the model one cycle later.
- CNTW=2 with 5 non-zero samples -> nz_count reaches 3 and stays at 3.
- rst_n pulsed low mid-stream between clock edges -> outputs reach reset values immediately; the next accepted sample after release is correct.
